// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: receives fixed-length UART frames, checks the message ID,
// replies with a frame byte by byte and watches the link for silence.
module uart_frame_ctrl #(
  parameter int          BUFFER_SIZE = 80,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter logic [31:0] TIMEOUT     = 32'd4800000,
  parameter logic [15:0] GAP_TIMEOUT = 16'd240
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_byte_valid,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_byte,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   rx_frame_valid,
  output logic                   link_ok,
  output logic [7:0]             err_msgid_cnt,
  output logic [7:0]             err_gap_cnt
);
  localparam int NBYTES = BUFFER_SIZE / 8;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  typedef enum logic [2:0] {IDLE, RECV, CHECK, TX_LOAD, TX_ACK, TX_DRAIN} state_e;
  state_e state_q, state_d;
  logic [BUFFER_SIZE-1:0] rx_buf_q, rx_buf_d, tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d, tx_idx_q, tx_idx_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0] ack_cnt_q, ack_cnt_d;
  logic [7:0] tx_byte_q, tx_byte_d, err_msgid_q, err_msgid_d, err_gap_q, err_gap_d;
  logic tx_start_q, tx_start_d, rfv_q, rfv_d, link_ok_q, link_ok_d;
  logic id_ok, gap_abort, accept;
  assign id_ok = rx_buf_q[BUFFER_SIZE-1 -: 32] == MSGID;
  // the silent cycle that would bring gap_cnt up to GAP_TIMEOUT aborts the frame
  assign gap_abort = state_q == RECV && !rx_byte_valid && gap_cnt_q == GAP_TIMEOUT - 16'd1;
  assign accept = state_q == CHECK && id_ok;
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_byte_valid) state_d = RECV;
      RECV:     if (rx_byte_valid && byte_cnt_q == LAST) state_d = CHECK;
                else if (gap_abort) state_d = IDLE;
      CHECK:    state_d = id_ok ? TX_LOAD : IDLE;
      TX_LOAD:  if (!tx_busy) state_d = TX_ACK;
      TX_ACK:   if (tx_busy || ack_cnt_q == 2'd3) state_d = TX_DRAIN;
      TX_DRAIN: if (!tx_busy) state_d = tx_idx_q == LAST ? IDLE : TX_LOAD;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    rx_buf_d = rx_buf_q;
    tx_buf_d = tx_buf_q;
    rx_data_d = rx_data_q;
    byte_cnt_d = byte_cnt_q;
    tx_idx_d = tx_idx_q;
    gap_cnt_d = gap_cnt_q;
    ack_cnt_d = ack_cnt_q;
    tx_byte_d = tx_byte_q;
    err_msgid_d = err_msgid_q;
    err_gap_d = err_gap_q;
    tx_start_d = 1'b0;
    rfv_d = 1'b0;
    link_ok_d = link_ok_q;
    wd_d = wd_q == TIMEOUT ? wd_q : wd_q + 32'd1;
    case (state_q)
      IDLE: if (rx_byte_valid) begin
        rx_buf_d = {rx_buf_q[BUFFER_SIZE-9:0], rx_byte};
        byte_cnt_d = CW'(1);
        gap_cnt_d = '0;
      end
      RECV: if (rx_byte_valid) begin
        rx_buf_d = {rx_buf_q[BUFFER_SIZE-9:0], rx_byte};
        byte_cnt_d = byte_cnt_q + CW'(1);
        gap_cnt_d = '0;
      end else if (gap_abort) begin
        rx_buf_d = '0;
        err_gap_d = err_gap_q + {7'd0, err_gap_q != 8'hFF};
      end else gap_cnt_d = gap_cnt_q + 16'd1;
      CHECK: if (id_ok) begin
        rx_data_d = rx_buf_q;
        rfv_d = 1'b1;
        tx_buf_d = tx_data;
        tx_idx_d = '0;
        wd_d = '0;
        link_ok_d = 1'b1;
      end else err_msgid_d = err_msgid_q + {7'd0, err_msgid_q != 8'hFF};
      TX_LOAD: begin
        ack_cnt_d = '0;
        tx_start_d = !tx_busy;
        tx_byte_d = tx_busy ? tx_byte_q : tx_buf_q[BUFFER_SIZE-1 -: 8];
      end
      TX_ACK: ack_cnt_d = ack_cnt_q + 2'd1;
      TX_DRAIN: if (!tx_busy && tx_idx_q != LAST) begin
        tx_buf_d = {tx_buf_q[BUFFER_SIZE-9:0], 8'h00};
        tx_idx_d = tx_idx_q + CW'(1);
      end
      default: ;
    endcase
    // expiry drops the link but lets any reply in flight finish; acceptance wins a tie
    if (wd_d == TIMEOUT && !accept) begin
      link_ok_d = 1'b0;
      rx_data_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf_q <= '0;
      tx_buf_q <= '0;
      rx_data_q <= '0;
      byte_cnt_q <= '0;
      tx_idx_q <= '0;
      gap_cnt_q <= '0;
      ack_cnt_q <= '0;
      wd_q <= '0;
      tx_byte_q <= '0;
      err_msgid_q <= '0;
      err_gap_q <= '0;
      tx_start_q <= 1'b0;
      rfv_q <= 1'b0;
      link_ok_q <= 1'b0;
    end else begin
      rx_buf_q <= rx_buf_d;
      tx_buf_q <= tx_buf_d;
      rx_data_q <= rx_data_d;
      byte_cnt_q <= byte_cnt_d;
      tx_idx_q <= tx_idx_d;
      gap_cnt_q <= gap_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      wd_q <= wd_d;
      tx_byte_q <= tx_byte_d;
      err_msgid_q <= err_msgid_d;
      err_gap_q <= err_gap_d;
      tx_start_q <= tx_start_d;
      rfv_q <= rfv_d;
      link_ok_q <= link_ok_d;
    end
  end
  assign tx_start = tx_start_q;
  assign tx_byte = tx_byte_q;
  assign rx_data = rx_data_q;
  assign rx_frame_valid = rfv_q;
  assign link_ok = link_ok_q;
  assign err_msgid_cnt = err_msgid_q;
  assign err_gap_cnt = err_gap_q;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed checks of uart_frame_ctrl with a simple
// transmitter model that holds tx_busy for busy_len cycles per tx_start.
module tb_uart_frame_ctrl;
  localparam logic [79:0] GOOD = 80'h74697277010203040506;
  localparam logic [79:0] BAD  = 80'h75697277010203040506;
  localparam logic [79:0] TXA  = 80'hA0A1A2A3A4A5A6A7A8A9;
  localparam logic [79:0] TXB  = 80'hB0B1B2B3B4B5B6B7B8B9;
  logic clk, rst, rx_byte_valid, tx_busy, tx_start, rx_frame_valid, link_ok;
  logic [7:0] rx_byte, tx_byte, err_msgid_cnt, err_gap_cnt;
  logic [79:0] tx_data, rx_data;
  int errors = 0, checks = 0;
  int cyc = 0, n_tx = 0, n_rfv = 0, rfv_cyc = 0, last_cyc = 0;
  int busy_len = 0, busy_cnt = 0, b_tx, b_rfv, t_fall;
  logic [7:0] tx_log [0:255];
  int tx_cyc [0:255];
  uart_frame_ctrl #(.BUFFER_SIZE(80), .MSGID(32'h74697277), .TIMEOUT(32'd1000),
                    .GAP_TIMEOUT(16'd20)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte), .tx_data(tx_data),
    .rx_data(rx_data), .rx_frame_valid(rx_frame_valid), .link_ok(link_ok),
    .err_msgid_cnt(err_msgid_cnt), .err_gap_cnt(err_gap_cnt));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) busy_cnt <= tx_start === 1'b1 ? busy_len : (busy_cnt > 0 ? busy_cnt - 1 : 0);
  assign tx_busy = busy_cnt != 0;
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_log[n_tx] = tx_byte;
      tx_cyc[n_tx] = cyc;
      n_tx++;
    end
    if (rx_frame_valid === 1'b1) begin
      n_rfv++;
      rfv_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int idle);
    rx_byte = b;
    rx_byte_valid = 1'b1;
    last_cyc = cyc;
    @(negedge clk);
    rx_byte_valid = 1'b0;
    repeat (idle) @(negedge clk);
  endtask
  task automatic send_frame(input logic [79:0] f, input int n, input int gi, input int gl);
    for (int i = 0; i < n; i++) send_byte(f[79-8*i -: 8], i == gi ? gl : 0);
  endtask
  task automatic wait_tx(input int base, input int n);
    for (int i = 0; i < 3000 && n_tx - base < n; i++) @(negedge clk);
    repeat (busy_len + 20) @(negedge clk);
  endtask
  function automatic logic [79:0] txbytes(input int base);
    logic [79:0] v = '0;
    for (int i = 0; i < 10; i++) v = {v[71:0], tx_log[base+i]};
    return v;
  endfunction
  initial begin
    rst = 1'b1; rx_byte = '0; rx_byte_valid = 1'b0; tx_data = TXA;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 80'(tx_start), 80'd0);
    chk("rst_tx_byte", 80'(tx_byte), 80'd0);
    chk("rst_rx_data", rx_data, 80'd0);
    chk("rst_rfv", 80'(rx_frame_valid), 80'd0);
    chk("rst_link_ok", 80'(link_ok), 80'd0);
    chk("rst_err_msgid", 80'(err_msgid_cnt), 80'd0);
    chk("rst_err_gap", 80'(err_gap_cnt), 80'd0);
    rst = 1'b0;
    @(negedge clk);
    // good frame; transmitter never raises busy, so every byte goes through the ack timeout
    b_tx = n_tx; b_rfv = n_rfv;
    send_frame(GOOD, 10, -1, 0);
    wait_tx(b_tx, 10);
    chk("good_rfv_cnt", 80'(n_rfv - b_rfv), 80'd1);
    chk("good_rfv_latency", 80'(rfv_cyc - last_cyc), 80'd2);
    chk("good_tx_latency", 80'(tx_cyc[b_tx] - last_cyc), 80'd3);
    chk("good_rx_data", rx_data, GOOD);
    chk("good_tx_cnt", 80'(n_tx - b_tx), 80'd10);
    chk("good_tx_bytes", txbytes(b_tx), TXA);
    chk("good_link_ok", 80'(link_ok), 80'd1);
    b_tx = n_tx; b_rfv = n_rfv;
    send_frame(BAD, 10, -1, 0);
    repeat (20) @(negedge clk);
    chk("bad_rfv_cnt", 80'(n_rfv - b_rfv), 80'd0);
    chk("bad_err_msgid", 80'(err_msgid_cnt), 80'd1);
    chk("bad_rx_data", rx_data, GOOD);
    chk("bad_tx_cnt", 80'(n_tx - b_tx), 80'd0);
    busy_len = 3; tx_data = TXB;
    b_tx = n_tx; b_rfv = n_rfv;
    send_frame(GOOD, 10, 4, 19);
    wait_tx(b_tx, 10);
    chk("gap19_rfv_cnt", 80'(n_rfv - b_rfv), 80'd1);
    chk("gap19_err_gap", 80'(err_gap_cnt), 80'd0);
    chk("gap19_tx_bytes", txbytes(b_tx), TXB);
    b_tx = n_tx; b_rfv = n_rfv;
    send_frame(GOOD, 5, 4, 20);
    send_frame(GOOD, 10, -1, 0);
    wait_tx(b_tx, 10);
    chk("gap20_err_gap", 80'(err_gap_cnt), 80'd1);
    chk("gap20_rfv_cnt", 80'(n_rfv - b_rfv), 80'd1);
    chk("gap20_rx_data", rx_data, GOOD);
    busy_len = 50; tx_data = TXA;
    b_tx = n_tx; b_rfv = n_rfv;
    send_frame(GOOD, 10, -1, 0);
    for (int i = 0; i < 50 && n_rfv == b_rfv; i++) @(negedge clk);
    send_frame(GOOD, 10, -1, 0);
    wait_tx(b_tx, 10);
    chk("busy_rfv_cnt", 80'(n_rfv - b_rfv), 80'd1);
    chk("busy_tx_cnt", 80'(n_tx - b_tx), 80'd10);
    chk("busy_tx_bytes", txbytes(b_tx), TXA);
    chk("busy_err_msgid", 80'(err_msgid_cnt), 80'd1);
    busy_len = 0;
    b_tx = n_tx; b_rfv = n_rfv;
    send_frame(GOOD, 10, -1, 0);
    wait_tx(b_tx, 10);
    for (int i = 0; i < 1200 && link_ok === 1'b1; i++) @(negedge clk);
    t_fall = cyc;
    chk("wd_expiry_cycle", 80'(t_fall - rfv_cyc), 80'd1000);
    chk("wd_link_ok", 80'(link_ok), 80'd0);
    chk("wd_rx_data", rx_data, 80'd0);
    tx_data = TXB;
    b_tx = n_tx; b_rfv = n_rfv;
    send_frame(GOOD, 10, -1, 0);
    wait_tx(b_tx, 10);
    chk("wd_relink", 80'(link_ok), 80'd1);
    chk("wd_rx_data2", rx_data, GOOD);
    chk("wd_tx_bytes", txbytes(b_tx), TXB);
    // reset in the middle of a reply must stop further tx_start pulses
    busy_len = 50;
    b_tx = n_tx;
    send_frame(GOOD, 10, -1, 0);
    for (int i = 0; i < 500 && n_tx - b_tx < 2; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b_tx = n_tx;
    repeat (200) @(negedge clk);
    chk("rst_tx_no_start", 80'(n_tx - b_tx), 80'd0);
    busy_len = 3;
    send_frame(GOOD, 6, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_link_ok", 80'(link_ok), 80'd0);
    chk("rstmid_rx_data", rx_data, 80'd0);
    chk("rstmid_err_msgid", 80'(err_msgid_cnt), 80'd0);
    chk("rstmid_err_gap", 80'(err_gap_cnt), 80'd0);
    chk("rstmid_tx_byte", 80'(tx_byte), 80'd0);
    rst = 1'b0;
    @(negedge clk);
    b_tx = n_tx; b_rfv = n_rfv;
    send_frame(GOOD, 10, -1, 0);
    wait_tx(b_tx, 10);
    chk("after_rst_rfv_cnt", 80'(n_rfv - b_rfv), 80'd1);
    chk("after_rst_rx_data", rx_data, GOOD);
    chk("after_rst_tx_cnt", 80'(n_tx - b_tx), 80'd10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 The block SHALL have parameter BUFFER_SIZE, default 80, meaning frame length in bits: a multiple of 8, at least 40; NBYTES = BUFFER_SIZE/8.
REQ-002 The block SHALL have parameter MSGID, default 32'h74697277, meaning the required value of the first 4 received bytes, MSB first.
REQ-003 The block SHALL have parameter TIMEOUT, default 32'd4800000, meaning link watchdog period in clk cycles.
REQ-004 The block SHALL have parameter GAP_TIMEOUT, default 16'd240, meaning the maximum clk cycles allowed between bytes within a frame.
REQ-005 Port clk  input  1  is the system clock; all logic is on its rising edge.
REQ-006 Port rst  input  1  is the reset: synchronous, active-high.
REQ-007 Port rx_byte  input  8  is the received byte from the UART receiver.
REQ-008 Port rx_byte_valid  input  1  is a one-cycle strobe marking rx_byte valid.
REQ-009 Port tx_busy  input  1  is high while the UART transmitter is shifting a byte.
REQ-010 Port tx_start  output  1  is a one-cycle strobe that launches tx_byte.
REQ-011 Port tx_byte  output  8  is the byte to transmit.
REQ-012 Port tx_data  input  BUFFER_SIZE  is the reply frame, sampled once per accepted frame.
REQ-013 Port rx_data  output  BUFFER_SIZE  is the last accepted frame.
REQ-014 Port rx_frame_valid  output  1  is a one-cycle pulse on frame acceptance.
REQ-015 Port link_ok  output  1  is high while frames arrive within TIMEOUT.
REQ-016 Port err_msgid_cnt  output  8  counts rejected frames, saturating.
REQ-017 Port err_gap_cnt  output  8  counts gap-aborted frames, saturating.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, RECV, CHECK, TX_LOAD, TX_ACK and TX_DRAIN.
REQ-019 In IDLE, rx_byte_valid SHALL shift rx_byte into rx_buf LSB side, set byte_cnt=1, clear gap_cnt and enter RECV.
REQ-020 In RECV, rx_byte_valid SHALL shift rx_buf and increment byte_cnt; the byte making byte_cnt==NBYTES enters CHECK next cycle.
REQ-021 In RECV, gap_cnt SHALL increment on every cycle without rx_byte_valid and clear on every cycle with it.
REQ-022 In RECV, when gap_cnt reaches GAP_TIMEOUT, the FSM SHALL increment err_gap_cnt (saturating at 255) and return to IDLE, discarding rx_buf.
REQ-023 CHECK SHALL last exactly 1 cycle.
REQ-024 If rx_buf[BUFFER_SIZE-1 -: 32]==MSGID, CHECK SHALL set rx_data<=rx_buf, pulse rx_frame_valid, set tx_buf<=tx_data, set tx_idx=0, clear the watchdog, set link_ok=1 and enter TX_LOAD.
REQ-025 Otherwise, CHECK SHALL increment err_msgid_cnt (saturating at 255), leave rx_data unchanged and enter IDLE.
REQ-026 TX_LOAD: when tx_busy==0, the block SHALL drive tx_byte<=tx_buf[BUFFER_SIZE-1 -: 8] and tx_start=1 for exactly one cycle, then enter TX_ACK.
REQ-027 TX_ACK SHALL wait for tx_busy==1, then enter TX_DRAIN.
REQ-028 If tx_busy is not seen within 4 cycles, TX_ACK SHALL proceed to TX_DRAIN anyway.
REQ-029 TX_DRAIN SHALL wait for tx_busy==0.
REQ-030 From TX_DRAIN, if tx_idx==NBYTES-1, the FSM SHALL go to IDLE; else it SHALL shift tx_buf left 8, increment tx_idx and go to TX_LOAD.
REQ-031 Link is half-duplex: rx_byte_valid SHALL be ignored in CHECK, TX_LOAD, TX_ACK and TX_DRAIN.
REQ-032 The watchdog counter SHALL increment every cycle, saturate at TIMEOUT, and clear only on frame acceptance.
REQ-033 When the watchdog counter reaches TIMEOUT, the block SHALL force link_ok=0 and rx_data=0 on the same edge.
REQ-034 The transmit sequence in progress SHALL complete when the watchdog expires.
REQ-035 If frame acceptance and watchdog expiry coincide, acceptance SHALL win.
REQ-036 Latency from the last rx_byte_valid to rx_frame_valid SHALL be 2 cycles.
REQ-037 Latency from the last rx_byte_valid to the first tx_start SHALL be at most 3 cycles when tx_busy==0.

Reset
REQ-038 rst=1 SHALL force state=IDLE.
REQ-039 rst=1 SHALL clear byte_cnt, gap_cnt, tx_idx, watchdog, rx_buf and tx_buf.
REQ-040 rst=1 SHALL drive tx_start=0, tx_byte=0, rx_data=0, rx_frame_valid=0, link_ok=0, err_msgid_cnt=0 and err_gap_cnt=0.
REQ-041 rst=1 SHALL take effect mid-frame or mid-transmit on the next edge; any partial frame is dropped and no further tx_start is issued.

Verification (BUFFER_SIZE=80, NBYTES=10)
REQ-042 Good frame: bytes 74 69 72 77 01..06, tx_data=80'hA0A1..A9 -> rx_frame_valid 1 pulse; rx_data=80'h7469727701..06; 10 tx_start pulses, bytes A0..A9 in order; link_ok=1.
REQ-043 Bad MSGID: first byte 75, rest as above -> no rx_frame_valid; err_msgid_cnt=1; rx_data unchanged; no tx_start.
REQ-044 Gap abort: 5 bytes, then silence for GAP_TIMEOUT cycles, then a good frame -> err_gap_cnt=1; only the second frame is accepted.
REQ-045 Watchdog: TIMEOUT=1000, one good frame then silence -> link_ok=0 and rx_data=0 exactly 1000 cycles after acceptance; next good frame -> link_ok=1.
REQ-046 tx_busy held high 50 cycles per byte -> exactly one tx_start per byte; bytes received during transmit are ignored.
REQ-047 rst asserted after byte 6 of a frame -> all outputs 0; the following complete good frame is accepted normally.
